// File: rtl/madgwick_wb_stream.sv
// Wishbone front-end for the Madgwick core: sample/result FIFOs,
// single-shot/continuous dispatch FSM, sample counter and interrupts.
module madgwick_wb_stream #(
  parameter int ACC_WIDTH  = 16,
  parameter int GYRO_WIDTH = 16,
  parameter int Q_WIDTH    = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  we_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  inta_o,
  output logic                  core_rst_n,
  output logic                  core_valid_in,
  input  logic                  core_ready_in,
  output logic [ACC_WIDTH-1:0]  core_a_x,
  output logic [ACC_WIDTH-1:0]  core_a_y,
  output logic [ACC_WIDTH-1:0]  core_a_z,
  output logic [GYRO_WIDTH-1:0] core_w_x,
  output logic [GYRO_WIDTH-1:0] core_w_y,
  output logic [GYRO_WIDTH-1:0] core_w_z,
  input  logic                  core_valid_out,
  output logic                  core_ready_out,
  input  logic [Q_WIDTH-1:0]    core_q_w,
  input  logic [Q_WIDTH-1:0]    core_q_x,
  input  logic [Q_WIDTH-1:0]    core_q_y,
  input  logic [Q_WIDTH-1:0]    core_q_z
);
  localparam int IW = 3 * ACC_WIDTH + 3 * GYRO_WIDTH;
  localparam int OW = 4 * Q_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [ADR_WIDTH-1:0] A_CTRL = ADR_WIDTH'(8'h00);
  localparam logic [ADR_WIDTH-1:0] A_STAT = ADR_WIDTH'(8'h04);
  localparam logic [ADR_WIDTH-1:0] A_AX   = ADR_WIDTH'(8'h08);
  localparam logic [ADR_WIDTH-1:0] A_AY   = ADR_WIDTH'(8'h0C);
  localparam logic [ADR_WIDTH-1:0] A_AZ   = ADR_WIDTH'(8'h10);
  localparam logic [ADR_WIDTH-1:0] A_WX   = ADR_WIDTH'(8'h14);
  localparam logic [ADR_WIDTH-1:0] A_WY   = ADR_WIDTH'(8'h18);
  localparam logic [ADR_WIDTH-1:0] A_WZ   = ADR_WIDTH'(8'h1C);
  localparam logic [ADR_WIDTH-1:0] A_QW   = ADR_WIDTH'(8'h20);
  localparam logic [ADR_WIDTH-1:0] A_QX   = ADR_WIDTH'(8'h24);
  localparam logic [ADR_WIDTH-1:0] A_QY   = ADR_WIDTH'(8'h28);
  localparam logic [ADR_WIDTH-1:0] A_QZ   = ADR_WIDTH'(8'h2C);
  localparam logic [ADR_WIDTH-1:0] A_CNT  = ADR_WIDTH'(8'h30);
  localparam logic [ADR_WIDTH-1:0] A_THR  = ADR_WIDTH'(8'h34);

  logic                  r_en, r_cont, r_thr_en, r_ovf_en;
  logic                  r_start, r_ovf, r_done, r_discard;
  logic                  r_ack, r_int, r_core_rst;
  logic [31:0]           r_dat, r_cnt;
  logic [7:0]            r_thr;
  logic [1:0]            r_st;
  logic [ACC_WIDTH-1:0]  r_ax, r_ay, r_az;
  logic [GYRO_WIDTH-1:0] r_wx, r_wy, r_wz;
  logic [IW-1:0]         r_in_mem  [FIFO_DEPTH];
  logic [OW-1:0]         r_out_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CW-1:0]         r_in_cnt, r_out_cnt;

  logic          w_acc, w_wr, w_rd, w_ctrl_wr, w_stat_wr, w_flush;
  logic          w_in_full, w_in_empty, w_out_empty, w_busy;
  logic          w_in_push, w_in_pop, w_ovf_set;
  logic          w_res, w_out_push, w_out_pop, w_go;
  logic [OW-1:0] w_out_q;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_acc      = cyc_i & stb_i & ~r_ack;
  assign w_wr       = w_acc & we_i;
  assign w_rd       = w_acc & ~we_i;
  assign w_ctrl_wr  = w_wr & (adr_i == A_CTRL);
  assign w_stat_wr  = w_wr & (adr_i == A_STAT);
  assign w_flush    = w_ctrl_wr & dat_i[4];
  assign w_in_full  = r_in_cnt == CW'(FIFO_DEPTH);
  assign w_in_empty = r_in_cnt == '0;
  assign w_out_empty = r_out_cnt == '0;
  assign w_busy     = r_st != S_IDLE;
  assign w_unused   = ^dat_i;

  assign core_valid_in  = (r_st == S_ISSUE) & r_en;
  assign core_ready_out = (r_st == S_WAIT) & r_en;
  assign core_rst_n     = r_core_rst;
  assign {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} = r_in_mem[r_in_rp];

  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign w_in_pop   = core_valid_in & core_ready_in;
  assign w_in_push  = w_wr & (adr_i == A_WZ) & (~w_in_full | w_in_pop);
  assign w_ovf_set  = w_wr & (adr_i == A_WZ) & w_in_full & ~w_in_pop;
  assign w_res      = core_valid_out & core_ready_out;
  assign w_out_push = w_res & ~r_discard & ~w_flush;
  assign w_out_pop  = w_rd & (adr_i == A_QZ) & ~w_out_empty;
  assign w_out_q    = w_out_empty ? '0 : r_out_mem[r_out_rp];
  assign w_go = (r_st == S_IDLE) & r_en & ~w_in_empty & ~w_flush &
                (r_out_cnt < CW'(FIFO_DEPTH)) & (r_cont | r_start);

  assign dat_o  = r_dat;
  assign ack_o  = r_ack;
  assign inta_o = r_int;

  always_comb begin
    w_rdata = '0;
    case (adr_i)
      A_CTRL: w_rdata = {28'd0, r_ovf_en, r_thr_en, r_cont, r_en};
      A_STAT: w_rdata = {8'd0, 8'(r_out_cnt), 8'(r_in_cnt), 2'd0, r_done,
                         r_ovf, w_out_empty, w_in_empty, w_in_full, w_busy};
      A_AX:   w_rdata = 32'(r_ax);
      A_AY:   w_rdata = 32'(r_ay);
      A_AZ:   w_rdata = 32'(r_az);
      A_WX:   w_rdata = 32'(r_wx);
      A_WY:   w_rdata = 32'(r_wy);
      A_WZ:   w_rdata = 32'(r_wz);
      A_QW:   w_rdata = 32'(w_out_q[4*Q_WIDTH-1 -: Q_WIDTH]);
      A_QX:   w_rdata = 32'(w_out_q[3*Q_WIDTH-1 -: Q_WIDTH]);
      A_QY:   w_rdata = 32'(w_out_q[2*Q_WIDTH-1 -: Q_WIDTH]);
      A_QZ:   w_rdata = 32'(w_out_q[Q_WIDTH-1:0]);
      A_CNT:  w_rdata = r_cnt;
      A_THR:  w_rdata = {24'd0, r_thr};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat <= w_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_ovf_en, r_thr_en, r_cont, r_en} <= '0;
      r_thr <= '0;
      {r_ax, r_ay, r_az} <= '0;
      {r_wx, r_wy, r_wz} <= '0;
    end else if (w_wr) begin
      case (adr_i)
        A_CTRL: {r_ovf_en, r_thr_en, r_cont, r_en} <= dat_i[3:0];
        A_THR:  r_thr <= dat_i[7:0];
        A_AX:   r_ax <= dat_i[ACC_WIDTH-1:0];
        A_AY:   r_ay <= dat_i[ACC_WIDTH-1:0];
        A_AZ:   r_az <= dat_i[ACC_WIDTH-1:0];
        A_WX:   r_wx <= dat_i[GYRO_WIDTH-1:0];
        A_WY:   r_wy <= dat_i[GYRO_WIDTH-1:0];
        A_WZ:   r_wz <= dat_i[GYRO_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= S_IDLE;
    end else if (!r_en) begin
      r_st <= S_IDLE;
    end else begin
      case (r_st)
        S_IDLE:  if (w_go) r_st <= S_ISSUE;
        S_ISSUE: if (w_flush) r_st <= S_IDLE;
                 else if (w_in_pop) r_st <= S_WAIT;
        S_WAIT:  if (w_res) r_st <= S_IDLE;
        default: r_st <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_in_mem[i] <= '0;
    end else if (w_flush) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wp] <= {r_ax, r_ay, r_az, r_wx, r_wy,
                              dat_i[GYRO_WIDTH-1:0]};
        r_in_wp <= r_in_wp + PW'(1);
      end
      if (w_in_pop) r_in_rp <= r_in_rp + PW'(1);
      r_in_cnt <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_out_mem[i] <= '0;
    end else if (w_flush) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wp] <= {core_q_w, core_q_x, core_q_y, core_q_z};
        r_out_wp <= r_out_wp + PW'(1);
      end
      if (w_out_pop) r_out_rp <= r_out_rp + PW'(1);
      r_out_cnt <= r_out_cnt + CW'(w_out_push) - CW'(w_out_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
      r_discard  <= 1'b0;
      r_cnt      <= '0;
      r_int      <= 1'b0;
      r_core_rst <= 1'b0;
    end else begin
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_stat_wr & dat_i[4]) r_ovf <= 1'b0;
      if (w_out_push) r_done <= 1'b1;
      else if (w_stat_wr & dat_i[5]) r_done <= 1'b0;
      if (w_out_push) r_cnt <= r_cnt + 32'd1;
      if (w_ctrl_wr & dat_i[5]) r_start <= 1'b1;
      else if (w_flush | w_go) r_start <= 1'b0;
      // a flushed in-flight result must still be drained from the core
      if (w_res | ~r_en) r_discard <= 1'b0;
      else if (w_flush & (r_st == S_WAIT)) r_discard <= 1'b1;
      r_int <= (r_thr_en & (r_thr != 8'd0) & (8'(r_out_cnt) >= r_thr)) |
               (r_ovf_en & r_ovf);
      r_core_rst <= r_en;
    end
  end
endmodule
